// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared PPU modes, region map and OAM DMA types
package ppu_pkg;

  typedef enum logic [1:0] {
    MODE_HBLANK  = 2'd0,
    MODE_VBLANK  = 2'd1,
    MODE_OAMSCAN = 2'd2,
    MODE_DRAW    = 2'd3
  } ppu_mode_t;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_RD,
    DMA_WAIT,
    DMA_WR
  } dma_state_t;

  typedef enum logic [1:0] {
    REGION_VRAM,
    REGION_OAM,
    REGION_UNUSABLE,
    REGION_OTHER
  } region_t;

  typedef enum logic [1:0] {
    RSEL_ZERO,
    RSEL_FF,
    RSEL_VRAM,
    RSEL_OAM
  } rsel_t;

  localparam logic [15:0] VRAM_BASE       = 16'h8000;
  localparam logic [15:0] VRAM_LIMIT      = 16'h9FFF;
  localparam logic [15:0] OAM_BASE        = 16'hFE00;
  localparam logic [15:0] OAM_LIMIT       = 16'hFE9F;
  localparam logic [15:0] UNUSABLE_BASE   = 16'hFEA0;
  localparam logic [15:0] UNUSABLE_LIMIT  = 16'hFEFF;

  localparam int          DMA_LEN_DEFAULT = 160;
  // Echo-RAM source pages fold back onto work RAM
  localparam logic [7:0]  DMA_SRC_LIMIT   = 8'hDF;
  localparam logic [7:0]  DMA_SRC_FOLD    = 8'h20;

  function automatic region_t decode_region(input logic [15:0] addr);
    if (addr >= VRAM_BASE && addr <= VRAM_LIMIT) return REGION_VRAM;
    if (addr >= OAM_BASE && addr <= OAM_LIMIT) return REGION_OAM;
    if (addr >= UNUSABLE_BASE && addr <= UNUSABLE_LIMIT) return REGION_UNUSABLE;
    return REGION_OTHER;
  endfunction

endpackage

// File: rtl/vram_oam_arbiter_if.sv
// rtl/vram_oam_arbiter_if.sv - link between the arbiter and the OAM DMA engine
interface vram_oam_arbiter_if;
  logic        start;
  logic [7:0]  src;
  logic        mcyc_en;
  logic        busy;
  logic        ext_req;
  logic [15:0] ext_addr;
  logic [7:0]  ext_rdata;
  logic        ext_valid;
  logic        oam_we;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;

  modport master (
    input  start, src, mcyc_en, ext_rdata, ext_valid,
    output busy, ext_req, ext_addr, oam_we, oam_addr, oam_wdata
  );

  modport slave (
    output start, src, mcyc_en, ext_rdata, ext_valid,
    input  busy, ext_req, ext_addr, oam_we, oam_addr, oam_wdata
  );
endinterface

// File: rtl/oam_dma_engine.sv
// rtl/oam_dma_engine.sv - OAM DMA: one source read and one OAM write per byte
module oam_dma_engine
  import ppu_pkg::*;
#(
  parameter int DMA_LEN = DMA_LEN_DEFAULT
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  vram_oam_arbiter_if.master  dma
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_t  state;
  logic [7:0]  src_q;
  logic [7:0]  idx_q;
  logic [7:0]  byte_q;
  logic [15:0] ext_addr_q;
  logic        ext_req_q;
  logic        busy_q;
  logic        wr_q;
  logic [7:0]  src_eff;

  assign src_eff = (dma.src > DMA_SRC_LIMIT) ? dma.src - DMA_SRC_FOLD : dma.src;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= DMA_IDLE;
      src_q      <= '0;
      idx_q      <= '0;
      byte_q     <= '0;
      ext_addr_q <= '0;
      ext_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      ext_req_q <= 1'b0;
      wr_q      <= 1'b0;
      // A start in any state restarts; a byte still in flight is simply dropped
      if (dma.start) begin
        src_q  <= src_eff;
        idx_q  <= '0;
        busy_q <= 1'b1;
        state  <= DMA_RD;
      end else begin
        case (state)
          DMA_IDLE: ;
          DMA_RD: begin
            if (dma.mcyc_en) begin
              ext_req_q  <= 1'b1;
              ext_addr_q <= {src_q, idx_q};
              state      <= DMA_WAIT;
            end
          end
          DMA_WAIT: begin
            if (dma.ext_valid) begin
              byte_q <= dma.ext_rdata;
              wr_q   <= 1'b1;
              state  <= DMA_WR;
            end
          end
          DMA_WR: begin
            if (idx_q == LAST_IDX) begin
              busy_q <= 1'b0;
              state  <= DMA_IDLE;
            end else begin
              idx_q <= idx_q + 8'd1;
              state <= DMA_RD;
            end
          end
          default: state <= DMA_IDLE;
        endcase
      end
    end
  end

  assign dma.oam_we    = wr_q & ~dma.start;
  assign dma.oam_addr  = idx_q;
  assign dma.oam_wdata = byte_q;
  assign dma.busy      = busy_q;
  assign dma.ext_req   = ext_req_q;
  assign dma.ext_addr  = ext_addr_q;

endmodule

// File: rtl/vram_oam_arbiter.sv
// rtl/vram_oam_arbiter.sv - VRAM/OAM arbitration between CPU, PPU and OAM DMA
module vram_oam_arbiter
  import ppu_pkg::*;
#(
  parameter int DMA_LEN = DMA_LEN_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [1:0]  mode_in,
  input  logic        lcd_en_in,
  input  logic        mcyc_en_in,
  input  logic        cpu_req_in,
  input  logic        cpu_we_in,
  input  logic [15:0] cpu_addr_in,
  input  logic [7:0]  cpu_wdata_in,
  output logic        cpu_ack_out,
  output logic [7:0]  cpu_rdata_out,
  input  logic        ppu_req_in,
  input  logic [15:0] ppu_addr_in,
  output logic        ppu_valid_out,
  output logic [7:0]  ppu_data_out,
  input  logic        dma_start_in,
  input  logic [7:0]  dma_src_in,
  output logic        dma_busy_out,
  output logic [12:0] vram_addr_out,
  output logic        vram_we_out,
  output logic [7:0]  vram_wdata_out,
  input  logic [7:0]  vram_rdata_in,
  output logic [7:0]  oam_addr_out,
  output logic        oam_we_out,
  output logic [7:0]  oam_wdata_out,
  input  logic [7:0]  oam_rdata_in,
  output logic        ext_req_out,
  output logic [15:0] ext_addr_out,
  input  logic [7:0]  ext_rdata_in,
  input  logic        ext_valid_in
);

  vram_oam_arbiter_if dma_if ();

  assign dma_if.start     = dma_start_in;
  assign dma_if.src       = dma_src_in;
  assign dma_if.mcyc_en   = mcyc_en_in;
  assign dma_if.ext_rdata = ext_rdata_in;
  assign dma_if.ext_valid = ext_valid_in;
  assign dma_busy_out     = dma_if.busy;
  assign ext_req_out      = dma_if.ext_req;
  assign ext_addr_out     = dma_if.ext_addr;

  oam_dma_engine #(.DMA_LEN(DMA_LEN)) u_dma (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .dma      (dma_if)
  );

  ppu_mode_t mode;
  region_t   cpu_region;
  region_t   ppu_region;
  logic      ppu_owns_vram, ppu_owns_oam;
  logic      ppu_vram_gnt, ppu_oam_gnt, cpu_vram_gnt, cpu_oam_gnt;
  rsel_t     cpu_sel_d, cpu_sel_q;
  logic      ppu_sel_oam_q;

  assign mode       = ppu_mode_t'(mode_in);
  assign cpu_region = decode_region(cpu_addr_in);
  assign ppu_region = decode_region(ppu_addr_in);

  // Ownership is by PPU mode, so a CPU colliding with the PPU is always the loser
  assign ppu_owns_vram = lcd_en_in && (mode == MODE_DRAW);
  assign ppu_owns_oam  = lcd_en_in && (mode == MODE_OAMSCAN || mode == MODE_DRAW);
  assign ppu_vram_gnt  = ppu_req_in && ppu_owns_vram && (ppu_region == REGION_VRAM);
  assign ppu_oam_gnt   = ppu_req_in && ppu_owns_oam && !dma_if.busy && (ppu_region == REGION_OAM);
  assign cpu_vram_gnt  = cpu_req_in && !ppu_owns_vram && (cpu_region == REGION_VRAM);
  assign cpu_oam_gnt   = cpu_req_in && !ppu_owns_oam && !dma_if.busy && (cpu_region == REGION_OAM);

  always_comb begin
    vram_addr_out  = '0;
    vram_we_out    = 1'b0;
    vram_wdata_out = '0;
    if (ppu_vram_gnt) begin
      vram_addr_out = ppu_addr_in[12:0];
    end else if (cpu_vram_gnt) begin
      vram_addr_out  = cpu_addr_in[12:0];
      vram_we_out    = cpu_we_in;
      vram_wdata_out = cpu_wdata_in;
    end
  end

  always_comb begin
    oam_addr_out  = '0;
    oam_we_out    = 1'b0;
    oam_wdata_out = '0;
    if (dma_if.oam_we) begin
      oam_addr_out  = dma_if.oam_addr;
      oam_we_out    = 1'b1;
      oam_wdata_out = dma_if.oam_wdata;
    end else if (ppu_oam_gnt) begin
      oam_addr_out = ppu_addr_in[7:0];
    end else if (cpu_oam_gnt) begin
      oam_addr_out  = cpu_addr_in[7:0];
      oam_we_out    = cpu_we_in;
      oam_wdata_out = cpu_wdata_in;
    end
  end

  always_comb begin
    cpu_sel_d = RSEL_FF;
    if (cpu_we_in) begin
      cpu_sel_d = RSEL_ZERO;
    end else begin
      case (cpu_region)
        REGION_VRAM:     cpu_sel_d = cpu_vram_gnt ? RSEL_VRAM : RSEL_FF;
        REGION_OAM:      cpu_sel_d = cpu_oam_gnt ? RSEL_OAM : RSEL_FF;
        REGION_UNUSABLE: cpu_sel_d = RSEL_ZERO;
        default:         cpu_sel_d = RSEL_FF;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cpu_ack_out   <= 1'b0;
      cpu_sel_q     <= RSEL_ZERO;
      ppu_valid_out <= 1'b0;
      ppu_sel_oam_q <= 1'b0;
    end else begin
      cpu_ack_out   <= cpu_req_in;
      cpu_sel_q     <= cpu_req_in ? cpu_sel_d : RSEL_ZERO;
      ppu_valid_out <= ppu_vram_gnt || ppu_oam_gnt;
      ppu_sel_oam_q <= ppu_oam_gnt;
    end
  end

  // Memory read data arrives one clock after the address, aligned with the ack
  always_comb begin
    case (cpu_sel_q)
      RSEL_VRAM: cpu_rdata_out = vram_rdata_in;
      RSEL_OAM:  cpu_rdata_out = oam_rdata_in;
      RSEL_FF:   cpu_rdata_out = 8'hFF;
      default:   cpu_rdata_out = 8'h00;
    endcase
  end

  assign ppu_data_out = !ppu_valid_out ? 8'h00 : (ppu_sel_oam_q ? oam_rdata_in : vram_rdata_in);

endmodule

// File: tb/tb_vram_oam_arbiter.sv
// tb/tb_vram_oam_arbiter.sv - directed bench for vram_oam_arbiter
module tb_vram_oam_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [1:0]  mode_in;
  logic        lcd_en_in;
  logic        mcyc_en_in;
  logic        cpu_req_in, cpu_we_in;
  logic [15:0] cpu_addr_in;
  logic [7:0]  cpu_wdata_in;
  logic        cpu_ack_out;
  logic [7:0]  cpu_rdata_out;
  logic        ppu_req_in;
  logic [15:0] ppu_addr_in;
  logic        ppu_valid_out;
  logic [7:0]  ppu_data_out;
  logic        dma_start_in;
  logic [7:0]  dma_src_in;
  logic        dma_busy_out;
  logic [12:0] vram_addr_out;
  logic        vram_we_out;
  logic [7:0]  vram_wdata_out;
  logic [7:0]  vram_rdata_in;
  logic [7:0]  oam_addr_out;
  logic        oam_we_out;
  logic [7:0]  oam_wdata_out;
  logic [7:0]  oam_rdata_in;
  logic        ext_req_out;
  logic [15:0] ext_addr_out;
  logic [7:0]  ext_rdata_in;
  logic        ext_valid_in;

  vram_oam_arbiter dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .mode_in(mode_in), .lcd_en_in(lcd_en_in),
    .mcyc_en_in(mcyc_en_in), .cpu_req_in(cpu_req_in), .cpu_we_in(cpu_we_in),
    .cpu_addr_in(cpu_addr_in), .cpu_wdata_in(cpu_wdata_in), .cpu_ack_out(cpu_ack_out),
    .cpu_rdata_out(cpu_rdata_out), .ppu_req_in(ppu_req_in), .ppu_addr_in(ppu_addr_in),
    .ppu_valid_out(ppu_valid_out), .ppu_data_out(ppu_data_out), .dma_start_in(dma_start_in),
    .dma_src_in(dma_src_in), .dma_busy_out(dma_busy_out), .vram_addr_out(vram_addr_out),
    .vram_we_out(vram_we_out), .vram_wdata_out(vram_wdata_out), .vram_rdata_in(vram_rdata_in),
    .oam_addr_out(oam_addr_out), .oam_we_out(oam_we_out), .oam_wdata_out(oam_wdata_out),
    .oam_rdata_in(oam_rdata_in), .ext_req_out(ext_req_out), .ext_addr_out(ext_addr_out),
    .ext_rdata_in(ext_rdata_in), .ext_valid_in(ext_valid_in)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ext_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  logic [7:0]  vram_mem [0:8191];
  logic [7:0]  oam_mem [0:255];
  logic [1:0]  mcnt = 2'd0;
  int          cyc = 0;
  int          oam_wr_cnt = 0;
  int          last_wr_cyc = 0;
  int          ext_req_cnt = 0;
  logic [15:0] last_ext_addr = '0;
  logic        ext_auto;
  logic        auto_valid = 1'b0;
  logic        man_valid;

  assign mcyc_en_in   = (mcnt == 2'd0);
  assign ext_valid_in = auto_valid | man_valid;

  // Memory, source-bus and write-monitor models
  always @(posedge clk_in) begin
    cyc  <= cyc + 1;
    mcnt <= mcnt + 2'd1;
    vram_rdata_in <= vram_mem[vram_addr_out];
    if (vram_we_out) vram_mem[vram_addr_out] <= vram_wdata_out;
    oam_rdata_in <= oam_mem[oam_addr_out];
    if (oam_we_out) begin
      oam_mem[oam_addr_out] <= oam_wdata_out;
      oam_wr_cnt  <= oam_wr_cnt + 1;
      last_wr_cyc <= cyc;
    end
    auto_valid <= ext_auto & ext_req_out;
    if (ext_req_out) begin
      ext_rdata_in  <= ext_byte(ext_addr_out);
      last_ext_addr <= ext_addr_out;
      ext_req_cnt   <= ext_req_cnt + 1;
    end
  end

  task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                            output logic ack, output logic [7:0] rd);
    @(negedge clk_in);
    cpu_req_in = 1'b1; cpu_we_in = we; cpu_addr_in = addr; cpu_wdata_in = wd;
    @(negedge clk_in);
    cpu_req_in = 1'b0; cpu_we_in = 1'b0;
    ack = cpu_ack_out;
    rd  = cpu_rdata_out;
  endtask

  task automatic dma_kick(input logic [7:0] src);
    @(negedge clk_in);
    dma_start_in = 1'b1; dma_src_in = src;
    @(negedge clk_in);
    dma_start_in = 1'b0;
  endtask

  task automatic wait_wr(input int target, input string tag);
    int n = 0;
    while (oam_wr_cnt < target && n < 5000) begin @(negedge clk_in); n++; end
    check_eq(tag, oam_wr_cnt >= target, 1);
  endtask

  task automatic wait_req(input int base, input string tag);
    int n = 0;
    while (ext_req_cnt <= base && n < 200) begin @(negedge clk_in); n++; end
    check_eq(tag, ext_req_cnt > base, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (dma_busy_out && n < 5000) begin @(negedge clk_in); n++; end
    check_eq(tag, dma_busy_out, 0);
  endtask

  logic       ack;
  logic [7:0] rd;
  int         base_wr, base_req, errs;

  initial begin
    rst_n_in = 1'b0; mode_in = 2'd0; lcd_en_in = 1'b0;
    cpu_req_in = 1'b0; cpu_we_in = 1'b0; cpu_addr_in = '0; cpu_wdata_in = '0;
    ppu_req_in = 1'b0; ppu_addr_in = '0; dma_start_in = 1'b0; dma_src_in = '0;
    ext_auto = 1'b1; man_valid = 1'b0;
    repeat (3) @(negedge clk_in);
    check_eq("rst_cpu_ack", cpu_ack_out, 0);
    check_eq("rst_ppu_valid", ppu_valid_out, 0);
    check_eq("rst_busy", dma_busy_out, 0);
    check_eq("rst_ext_req", ext_req_out, 0);
    check_eq("rst_cpu_rdata", cpu_rdata_out, 8'h00);
    check_eq("rst_ppu_data", ppu_data_out, 8'h00);
    check_eq("rst_oam_we", oam_we_out, 0);
    check_eq("rst_vram_we", vram_we_out, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    cpu_access(1'b1, 16'h8010, 8'h3C, ack, rd);
    check_eq("wr_vram_ack", ack, 1);
    cpu_access(1'b1, 16'hFE04, 8'h77, ack, rd);
    check_eq("wr_oam_ack", ack, 1);

    lcd_en_in = 1'b1; mode_in = 2'd3;
    cpu_access(1'b0, 16'h8010, 8'h00, ack, rd);
    check_eq("draw_vram_ack", ack, 1);
    check_eq("draw_vram_blocked", rd, 8'hFF);
    mode_in = 2'd0;
    cpu_access(1'b0, 16'h8010, 8'h00, ack, rd);
    check_eq("hblank_vram_rd", rd, 8'h3C);

    mode_in = 2'd2;
    @(negedge clk_in);
    cpu_req_in = 1'b1; cpu_we_in = 1'b0; cpu_addr_in = 16'hFE04;
    ppu_req_in = 1'b1; ppu_addr_in = 16'hFE04;
    @(negedge clk_in);
    cpu_req_in = 1'b0; ppu_req_in = 1'b0;
    check_eq("collide_ppu_valid", ppu_valid_out, 1);
    check_eq("collide_ppu_data", ppu_data_out, 8'h77);
    check_eq("collide_cpu_ack", cpu_ack_out, 1);
    check_eq("collide_cpu_rdata", cpu_rdata_out, 8'hFF);
    cpu_access(1'b0, 16'h8010, 8'h00, ack, rd);
    check_eq("scan_vram_rd", rd, 8'h3C);

    lcd_en_in = 1'b0; mode_in = 2'd0;
    @(negedge clk_in);
    ppu_req_in = 1'b1; ppu_addr_in = 16'hFE04;
    @(negedge clk_in);
    ppu_req_in = 1'b0;
    check_eq("lcd_off_ppu_valid", ppu_valid_out, 0);

    cpu_access(1'b0, 16'hFEA5, 8'h00, ack, rd);
    check_eq("unusable_rd", rd, 8'h00);
    base_wr = oam_wr_cnt;
    cpu_access(1'b1, 16'hFEA5, 8'h12, ack, rd);
    check_eq("unusable_wr_dropped", oam_wr_cnt, base_wr);
    cpu_access(1'b0, 16'h0123, 8'h00, ack, rd);
    check_eq("other_rd", rd, 8'hFF);

    base_wr = oam_wr_cnt; base_req = ext_req_cnt;
    dma_kick(8'hC1);
    check_eq("dma_c1_busy", dma_busy_out, 1);
    wait_req(base_req, "dma_c1_req_seen");
    check_eq("dma_c1_first_addr", last_ext_addr, 16'hC100);
    cpu_access(1'b0, 16'hFE00, 8'h00, ack, rd);
    check_eq("dma_cpu_oam_blocked", rd, 8'hFF);
    cpu_access(1'b0, 16'h8010, 8'h00, ack, rd);
    check_eq("dma_cpu_vram_rd", rd, 8'h3C);
    wait_idle("dma_c1_done");
    check_eq("dma_c1_busy_fall", cyc - last_wr_cyc, 1);
    check_eq("dma_c1_wr_cnt", oam_wr_cnt - base_wr, 160);
    errs = 0;
    for (int i = 0; i < 160; i++)
      if (oam_mem[i] !== ext_byte(16'hC100 + 16'(i))) errs++;
    check_eq("dma_c1_data_errs", errs, 0);

    base_wr = oam_wr_cnt; base_req = ext_req_cnt;
    dma_kick(8'hE3);
    wait_req(base_req, "dma_e3_req_seen");
    check_eq("dma_e3_first_addr", last_ext_addr, 16'hC300);
    wait_wr(base_wr + 50, "dma_e3_50_writes");
    ext_auto = 1'b0;
    base_req = ext_req_cnt;
    wait_req(base_req, "dma_e3_idx50_req");
    check_eq("dma_e3_idx50_addr", last_ext_addr, 16'hC332);
    base_wr = oam_wr_cnt;
    dma_src_in = 8'hD0; dma_start_in = 1'b1;
    @(negedge clk_in);
    dma_start_in = 1'b0; man_valid = 1'b1; ext_auto = 1'b1;
    base_req = ext_req_cnt;
    check_eq("restart_busy", dma_busy_out, 1);
    @(negedge clk_in);
    man_valid = 1'b0;
    wait_req(base_req, "restart_req_seen");
    check_eq("restart_first_addr", last_ext_addr, 16'hD000);
    check_eq("restart_no_stale_wr", oam_wr_cnt, base_wr);
    wait_idle("restart_done");
    check_eq("restart_wr_cnt", oam_wr_cnt - base_wr, 160);
    errs = 0;
    for (int i = 0; i < 160; i++)
      if (oam_mem[i] !== ext_byte(16'hD000 + 16'(i))) errs++;
    check_eq("restart_data_errs", errs, 0);

    base_wr = oam_wr_cnt;
    dma_kick(8'hC1);
    wait_wr(base_wr + 10, "rst_dma_10_writes");
    rst_n_in = 1'b0;
    #1;
    check_eq("rst_mid_busy", dma_busy_out, 0);
    check_eq("rst_mid_ext_req", ext_req_out, 0);
    base_wr = oam_wr_cnt;
    repeat (3) @(negedge clk_in);
    check_eq("rst_mid_oam_we", oam_we_out, 0);
    rst_n_in = 1'b1;
    repeat (20) @(negedge clk_in);
    check_eq("rst_mid_no_writes", oam_wr_cnt, base_wr);
    check_eq("rst_mid_idle", dma_busy_out, 0);
    cpu_access(1'b0, 16'hFEA5, 8'h00, ack, rd);
    check_eq("rst_mid_unusable_ack", ack, 1);
    check_eq("rst_mid_unusable_rd", rd, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_oam_arbiter.md
VRAM_OAM_ARBITER -- requirements
Module: vram_oam_arbiter

Interface
REQ-001 SHALL have parameter DMA_LEN, default 160, meaning the number of OAM bytes per DMA transfer.
REQ-002 SHALL have ports clk_in (in, 1, sole clock) and rst_n_in (in, 1, reset); reset is asynchronous and active-low.
REQ-003 SHALL have ports mode_in (in, 2, PPU mode: 0 HBlank, 1 VBlank, 2 OAMScan, 3 Draw), lcd_en_in (in, 1, LCDC[7]) and mcyc_en_in (in, 1, one-clk M-cycle strobe).
REQ-004 SHALL have CPU ports cpu_req_in (in, 1), cpu_we_in (in, 1), cpu_addr_in (in, 16), cpu_wdata_in (in, 8), cpu_ack_out (out, 1) and cpu_rdata_out (out, 8).
REQ-005 SHALL have PPU ports ppu_req_in (in, 1), ppu_addr_in (in, 16), ppu_valid_out (out, 1) and ppu_data_out (out, 8).
REQ-006 SHALL have DMA ports dma_start_in (in, 1, $FF46 write strobe), dma_src_in (in, 8, $FF46 value) and dma_busy_out (out, 1).
REQ-007 SHALL have VRAM ports vram_addr_out (out, 13), vram_we_out (out, 1), vram_wdata_out (out, 8) and vram_rdata_in (in, 8); read latency is 1 clk.
REQ-008 SHALL have OAM ports oam_addr_out (out, 8), oam_we_out (out, 1), oam_wdata_out (out, 8) and oam_rdata_in (in, 8); read latency is 1 clk.
REQ-009 SHALL have DMA-source bus ports ext_req_out (out, 1), ext_addr_out (out, 16), ext_rdata_in (in, 8) and ext_valid_in (in, 1).

Function
REQ-010 SHALL decode regions as VRAM $8000-$9FFF, OAM $FE00-$FE9F, and unusable $FEA0-$FEFF.
REQ-011 SHALL give OAM priority as DMA > PPU (lcd_en_in=1 and mode 2/3) > CPU.
REQ-012 SHALL give VRAM priority as PPU (lcd_en_in=1 and mode 3) > CPU.
REQ-013 SHALL allow the CPU full access to both memories whenever lcd_en_in=0 and no DMA is active.
REQ-014 SHALL set cpu_ack_out exactly 1 clk after each cpu_req_in cycle, whether or not access is granted.
REQ-015 SHALL return 0xFF on a blocked CPU read and drop a blocked CPU write.
REQ-016 SHALL return 0x00 on a read of $FEA0-$FEFF, drop writes to that range, and return 0xFF for any other address.
REQ-017 SHALL, on a granted PPU read, set ppu_valid_out with ppu_data_out 1 clk later; PPU requests made while lcd_en_in=0 SHALL be ignored (no valid).
REQ-018 SHALL, when the PPU and CPU hit the same memory in the same cycle, serve the PPU and complete the CPU as blocked.
REQ-019 SHALL implement a DMA FSM with states IDLE, RD, WAIT and WR.
REQ-020 SHALL, on dma_start_in in IDLE, latch src = (dma_src_in > 0xDF) ? dma_src_in - 0x20 : dma_src_in, clear idx, go to RD and raise dma_busy_out next clk.
REQ-021 SHALL, in RD on mcyc_en_in, pulse ext_req_out for 1 clk with ext_addr_out = {src, idx}, then go to WAIT.
REQ-022 SHALL, in WAIT on ext_valid_in, capture ext_rdata_in and go to WR.
REQ-023 SHALL, in WR, drive oam_we_out=1, oam_addr_out=idx and the captured byte for 1 clk; go to IDLE when idx == DMA_LEN-1, else increment idx and go to RD.
REQ-024 SHALL hold dma_busy_out=1 in RD, WAIT and WR, and drop it the clk after the final WR.
REQ-025 SHALL, on dma_start_in while busy, restart: re-latch src, set idx=0, go to RD, abandon any pending byte and ignore a late ext_valid_in.
REQ-026 SHALL let the CPU retain VRAM access during DMA, subject to REQ-012.
REQ-027 SHALL drive all write enables combinationally from the grant and never assert both a CPU write and a DMA write to OAM in the same cycle.

Reset
REQ-028 SHALL, while rst_n_in=0, hold the FSM in IDLE, idx=0, src=0, and all *_we_out, ext_req_out, cpu_ack_out, ppu_valid_out and dma_busy_out at 0.
REQ-029 SHALL hold cpu_rdata_out and ppu_data_out at 0x00 during reset.
REQ-030 SHALL, on reset asserted mid-DMA, abort immediately with no further OAM writes.

Structure
REQ-031 SHALL place the mode enum (HBlank/VBlank/OAMScan/Draw), region base/limit constants, DMA_LEN default and DMA state enum in shared package ppu_pkg.
REQ-032 SHALL implement the DMA FSM as sub-module oam_dma_engine, with arbitration and decode in the top module.

Verification
REQ-033 SHALL cover: lcd_en_in=1, mode 3, CPU read $8010 -> ack next clk with 0xFF and no VRAM access; in mode 0 the same read returns vram[0x010].
REQ-034 SHALL cover: mode 2, simultaneous PPU and CPU read of $FE04 -> ppu_valid_out returns oam[4] and CPU gets 0xFF.
REQ-035 SHALL cover: dma_start_in with src 0xC1 and a 1-clk ext_valid_in -> 160 OAM writes, oam[i] = mem[0xC100+i], then busy drops after idx 159.
REQ-036 SHALL cover: dma_src_in 0xE3 -> ext_addr_out starts at 0xC300.
REQ-037 SHALL cover: restart at idx 50 with src 0xD0 -> idx resets to 0, the next ext_addr_out is 0xD000 and no write occurs for the abandoned byte.
REQ-038 SHALL cover: rst_n_in pulsed low mid-DMA -> busy=0 asynchronously, no further oam_we_out, and CPU read $FEA5 returns 0x00.
